// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one synchronous single-port RAM between the CPU (port 0)
// and an auxiliary master (port 1), with round-robin or fixed-priority tie breaking.
module mem_arbiter #(
    parameter int ADDR_W     = 9,
    parameter int DATA_W     = 16,
    parameter int FIXED_PRIO = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        cmd0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              gnt0,
    output logic              rvalid0,
    output logic [DATA_W-1:0] rdata0,
    input  logic [1:0]        cmd1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_write,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy,
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        RDATA  = 2'b10
    } state_t;

    localparam logic [1:0] MREAD    = 2'b01;
    localparam logic [1:0] MWRITE   = 2'b11;
    localparam logic [1:0] MILLEGAL = 2'b10;

    state_t            state;
    state_t            state_next;
    logic              owner;
    logic              last_owner;
    logic [1:0]        cmd_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              err_q;
    logic              req0;
    logic              req1;
    logic              grant;
    logic              winner;

    always_comb begin
        req0       = (cmd0 == MREAD) || (cmd0 == MWRITE);
        req1       = (cmd1 == MREAD) || (cmd1 == MWRITE);
        grant      = req0 || req1;
        winner     = 1'b0;
        state_next = state;

        // On a tie, round-robin favours whoever did not own the last transaction.
        if (req0 && req1) begin
            winner = (FIXED_PRIO != 0) ? 1'b0 : ~last_owner;
        end else begin
            winner = req1;
        end

        case (state)
            IDLE:    state_next = grant ? ACCESS : IDLE;
            ACCESS:  state_next = (cmd_q == MWRITE) ? IDLE : RDATA;
            RDATA:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_owner <= 1'b1;
            cmd_q      <= 2'b00;
            addr_q     <= '0;
            wdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state <= state_next;
            if (state == IDLE && grant) begin
                owner      <= winner;
                last_owner <= winner;
                cmd_q      <= winner ? cmd1   : cmd0;
                addr_q     <= winner ? addr1  : addr0;
                wdata_q    <= winner ? wdata1 : wdata0;
            end
            if (cmd0 == MILLEGAL || cmd1 == MILLEGAL) begin
                err_q <= 1'b1;
            end
        end
    end

    // Outputs decode registered state only, so a write in flight still commits
    // during a reset cycle because the RAM samples at that same edge.
    assign gnt0      = (state == ACCESS) && !owner;
    assign gnt1      = (state == ACCESS) &&  owner;
    assign rvalid0   = (state == RDATA)  && !owner;
    assign rvalid1   = (state == RDATA)  &&  owner;
    assign rdata0    = rvalid0 ? ram_rdata : '0;
    assign rdata1    = rvalid1 ? ram_rdata : '0;
    assign ram_addr  = addr_q;
    assign ram_wdata = wdata_q;
    assign ram_write = (state == ACCESS) && (cmd_q == MWRITE);
    assign busy      = (state != IDLE);
    assign err       = err_q;

endmodule
